// File: rtl/check_point.sv
// Pipelined point-in-triangle tester using exact integer twice-areas.
// Three register stages: signed cross sums, magnitudes and sub-area sum, compare.
module check_point #(
    parameter int CW = 11,
    parameter int AW = 2 * CW,
    parameter int SW = 2 * CW + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [CW-1:0] ax,
    input  logic [CW-1:0] ay,
    input  logic [CW-1:0] bx,
    input  logic [CW-1:0] by,
    input  logic [CW-1:0] cx,
    input  logic [CW-1:0] cy,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    output logic          check,
    output logic [AW-1:0] area2,
    output logic          out_valid
);

    // Signed width of a 3-term cross sum; every intermediate fits exactly.
    localparam int XW = SW + 1;

    function automatic logic signed [XW-1:0] widen(input logic [CW-1:0] v);
        return signed'({{(XW-CW){1'b0}}, v});
    endfunction

    function automatic logic signed [XW-1:0] cross3(
        input logic [CW-1:0] ux, input logic [CW-1:0] uy,
        input logic [CW-1:0] vx, input logic [CW-1:0] vy,
        input logic [CW-1:0] wx, input logic [CW-1:0] wy
    );
        return widen(ux) * (widen(vy) - widen(wy))
             + widen(vx) * (widen(wy) - widen(uy))
             + widen(wx) * (widen(uy) - widen(vy));
    endfunction

    // Magnitude never exceeds (2^CW-1)^2, so the low AW bits hold it exactly.
    function automatic logic [AW-1:0] mag(input logic signed [XW-1:0] s);
        logic signed [XW-1:0] n;
        n = (s < 0) ? -s : s;
        return n[AW-1:0];
    endfunction

    logic signed [XW-1:0] c_abc, c_pab, c_pbc, c_pca;
    logic signed [XW-1:0] s_abc, s_pab, s_pbc, s_pca;
    logic                 v1;

    logic [AW-1:0] m_pab, m_pbc, m_pca;
    logic [AW-1:0] t_abc;
    logic [SW-1:0] sum;
    logic          v2;

    always_comb begin
        c_abc = cross3(ax, ay, bx, by, cx, cy);
        c_pab = cross3(px, py, ax, ay, bx, by);
        c_pbc = cross3(px, py, bx, by, cx, cy);
        c_pca = cross3(px, py, cx, cy, ax, ay);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_abc <= '0;
            s_pab <= '0;
            s_pbc <= '0;
            s_pca <= '0;
            v1    <= 1'b0;
        end else begin
            s_abc <= c_abc;
            s_pab <= c_pab;
            s_pbc <= c_pbc;
            s_pca <= c_pca;
            v1    <= in_valid;
        end
    end

    always_comb begin
        m_pab = mag(s_pab);
        m_pbc = mag(s_pbc);
        m_pca = mag(s_pca);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_abc <= '0;
            sum   <= '0;
            v2    <= 1'b0;
        end else begin
            t_abc <= mag(s_abc);
            sum   <= {{(SW-AW){1'b0}}, m_pab}
                   + {{(SW-AW){1'b0}}, m_pbc}
                   + {{(SW-AW){1'b0}}, m_pca};
            v2    <= v1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check     <= 1'b0;
            area2     <= '0;
            out_valid <= 1'b0;
        end else begin
            check     <= (sum == {{(SW-AW){1'b0}}, t_abc}) && (t_abc != '0);
            area2     <= t_abc;
            out_valid <= v2;
        end
    end

endmodule

// File: tb/tb_check_point.sv
// Scoreboard bench for check_point: expected results queued at drive time,
// compared when out_valid is due; reference uses the edge-sign inside test.
module tb_check_point;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] ax, ay, bx, by, cx, cy, px, py;
    logic        check;
    logic [21:0] area2;
    logic        out_valid;

    check_point #(.CW(11), .AW(22), .SW(24)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy), .px(px), .py(py),
        .check(check), .area2(area2), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        chk;
        logic [21:0] a2;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_eval = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_eval++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Independent reference: shoelace area plus same-side sign test.
    function automatic int orient(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2);
        return (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    endfunction

    function automatic exp_t model(input int a_x, input int a_y, input int b_x, input int b_y,
                                   input int c_x, input int c_y, input int p_x, input int p_y);
        exp_t e;
        int t, d1, d2, d3;
        t  = orient(a_x, a_y, b_x, b_y, c_x, c_y);
        d1 = orient(a_x, a_y, b_x, b_y, p_x, p_y);
        d2 = orient(b_x, b_y, c_x, c_y, p_x, p_y);
        d3 = orient(c_x, c_y, a_x, a_y, p_x, p_y);
        e.cyc = 0;
        e.a2  = 22'((t < 0) ? -t : t);
        e.chk = (t != 0) && ((d1 >= 0 && d2 >= 0 && d3 >= 0) || (d1 <= 0 && d2 <= 0 && d3 <= 0));
        return e;
    endfunction

    // Drive one valid vector at the negedge; result due after the 3rd register edge.
    task automatic drive(input int a_x, input int a_y, input int b_x, input int b_y,
                         input int c_x, input int c_y, input int p_x, input int p_y,
                         input logic use_const, input logic k_chk, input logic [21:0] k_a2);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        ax = 11'(a_x); ay = 11'(a_y); bx = 11'(b_x); by = 11'(b_y);
        cx = 11'(c_x); cy = 11'(c_y); px = 11'(p_x); py = 11'(p_y);
        e = model(a_x, a_y, b_x, b_y, c_x, c_y, p_x, p_y);
        if (use_const) begin
            e.chk = k_chk;
            e.a2  = k_a2;
        end
        e.cyc = cyc + 3;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            ax = 11'($urandom); px = 11'($urandom);
        end
    endtask

    // Monitor: out_valid must match the scoreboard timing exactly.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic due;
            exp_t e;
            due = (q.size() > 0) && (q[0].cyc == cyc);
            cmp("out_valid", 32'(out_valid), 32'(due));
            if (due) begin
                e = q.pop_front();
                cmp("check", 32'(check), 32'(e.chk));
                cmp("area2", 32'(area2), 32'(e.a2));
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                cmp("stale_entry", 32'(e.cyc), 32'(cyc));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1;
        ax = 11'd3; ay = 11'd4; bx = 11'd50; by = 11'd7; cx = 11'd9; cy = 11'd60;
        px = 11'd10; py = 11'd10;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_check", 32'(check), 32'd0);
        cmp("rst_area2", 32'(area2), 32'd0);

        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(4);

        drive(0, 0, 10, 0, 0, 10, 2, 2, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 10, 0, 0, 10, 10, 10, 1'b1, 1'b0, 22'd100);
        drive(0, 0, 10, 0, 0, 10, 5, 5, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 10, 0, 0, 10, 0, 0, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 0, 10, 10, 0, 2, 2, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 5, 5, 10, 10, 3, 3, 1'b1, 1'b0, 22'd0);
        drive(0, 0, 2047, 0, 0, 2047, 1023, 1023, 1'b1, 1'b1, 22'd4190209);
        drive(0, 0, 2047, 0, 0, 2047, 2047, 2047, 1'b1, 1'b0, 22'd4190209);
        drive(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 1'b1, 1'b0, 22'd0);
        idle(2);

        // Back-to-back with a bubble in the middle.
        drive(0, 0, 10, 0, 0, 10, 2, 2, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 10, 0, 0, 10, 10, 10, 1'b1, 1'b0, 22'd100);
        drive(0, 0, 5, 5, 10, 10, 3, 3, 1'b1, 1'b0, 22'd0);
        idle(1);
        drive(0, 0, 10, 0, 0, 10, 2, 2, 1'b1, 1'b1, 22'd100);

        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 3)
                drive($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                      $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
                      $urandom_range(0, 2047), $urandom_range(0, 2047), 1'b0, 1'b0, '0);
            else
                drive($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30),
                      $urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30),
                      $urandom_range(0, 30), $urandom_range(0, 30), 1'b0, 1'b0, '0);
            if (i % 7 == 6) idle(1);
        end
        idle(5);

        // Mid-flight reset: queued results must be discarded, no late out_valid.
        drive(0, 0, 10, 0, 0, 10, 2, 2, 1'b1, 1'b1, 22'd100);
        drive(0, 0, 10, 0, 0, 10, 2, 2, 1'b1, 1'b1, 22'd100);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        cmp("midrst_out_valid", 32'(out_valid), 32'd0);
        cmp("midrst_check", 32'(check), 32'd0);
        cmp("midrst_area2", 32'(area2), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(5);

        drive(0, 0, 2047, 0, 0, 2047, 1023, 1023, 1'b1, 1'b1, 22'd4190209);
        idle(1);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        cmp("drain_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
        $finish;
    end

endmodule
